// File: rtl/cnn_pkg.sv
// Shared constants for the layer RAM arbiter: requester IDs and arbiter state encoding.
package cnn_pkg;

  localparam int NUM_REQ  = 4;
  localparam int REQ_PCIE = 0;
  localparam int REQ_CONV = 1;
  localparam int REQ_POOL = 2;
  localparam int REQ_FC   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/layer_ram_arbiter_if.sv
// Requester-side bus of the layer RAM arbiter: per-requester request/beat
// fields going in, registered grant and read-return strobes coming back.
interface layer_ram_arbiter_if
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ-1:0]        last;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;

  modport master (
    output req, we, last, addr, wdata,
    input  gnt, rd_valid, rd_data
  );

  modport slave (
    input  req, we, last, addr, wdata,
    output gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: first set bit of eligible at or above
// ptr, wrapping 3 -> 0.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       found
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the closest hit to ptr wins last.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_ram_arbiter.sv
// Layer RAM arbiter: shares one RAM port among PCIe, conv, pool and fc
// engines with round-robin burst grants gated by req_mask, and returns read
// data with per-requester valid strobes aligned to RAM_LAT.
// Optional build macro LAYER_RAM_ARB_PCIE_PRIO_EN gives requester 0 strict
// priority in IDLE; requesters 1-3 keep round-robin among themselves.
//
// state | meaning
// IDLE  | no grant; arbitrate eligible requesters (also the release bubble)
// BUSY  | owner holds the RAM port until last, withdraw or MAX_BURST beats
module layer_ram_arbiter
  import cnn_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RAM_LAT   = 2,
  parameter int MAX_BURST = 256
) (
  input  logic                clk,
  input  logic                rst,
  layer_ram_arbiter_if.slave  bus,
  input  logic [NUM_REQ-1:0]  req_mask,
  input  logic                err_clr,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy,
  output logic                burst_err
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic [1:0]                 owner_q, owner_d;
  logic [1:0]                 ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [RAM_LAT-1:0]         rv_q, rv_d;
  logic [RAM_LAT-1:0][1:0]    rid_q, rid_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_elig;
  logic               prio_hit;
  logic [1:0]         winner;
  logic               found;
  logic               own_req, own_we, own_last;
  logic               beat, force_rel;

  assign eligible = bus.req & req_mask;

`ifdef LAYER_RAM_ARB_PCIE_PRIO_EN
  assign prio_hit  = eligible[REQ_PCIE];
  assign pick_elig = eligible & 4'b1110;
`else
  assign prio_hit  = 1'b0;
  assign pick_elig = eligible;
`endif

  rr_pick4 u_pick (
    .eligible (pick_elig),
    .ptr      (ptr_q),
    .winner   (winner),
    .found    (found)
  );

  assign own_req   = bus.req[owner_q];
  assign own_we    = bus.we[owner_q];
  assign own_last  = bus.last[owner_q];
  assign beat      = (state_q == BUSY) && own_req;
  assign force_rel = beat && !own_last && (cnt_q == CNT_LAST);

  assign ram_en    = beat;
  assign ram_we    = beat && own_we;
  assign ram_addr  = bus.addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign ram_wdata = bus.wdata[int'(owner_q)*DATA_W +: DATA_W];

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rv_q[RAM_LAT-1] ? (4'b0001 << rid_q[RAM_LAT-1]) : 4'b0000;
  assign bus.rd_data  = ram_rdata;
  assign busy         = (state_q == BUSY);
  assign burst_err    = err_q;

  // Arbitration, burst release and sticky error next-state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (prio_hit) begin
          state_d = BUSY;
          gnt_d   = 4'b0001;
          owner_d = 2'(REQ_PCIE);
          cnt_d   = '0;
        end else if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          cnt_d   = '0;
          ptr_d   = winner + 2'd1;
        end
      end
      BUSY: begin
        if (own_req) cnt_d = cnt_q + 1'b1;
        if (!own_req || own_last || force_rel) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = force_rel ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Read-return tag pipeline; drains independently of grant changes.
  always_comb begin
    rv_d     = '0;
    rid_d    = '0;
    rv_d[0]  = beat && !own_we;
    rid_d[0] = owner_q;
    for (int i = 1; i < RAM_LAT; i++) begin
      rv_d[i]  = rv_q[i-1];
      rid_d[i] = rid_q[i-1];
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
    end
  end

endmodule

// File: tb/tb_layer_ram_arbiter.sv
// Scoreboard bench for layer_ram_arbiter: expected grants and read returns
// are queued by the stimulus; a negedge monitor pops and compares them.
module tb_layer_ram_arbiter;
  import cnn_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_mask = 4'b1111;
  logic err_clr = 1'b0;
  logic ram_en, ram_we, busy, burst_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  layer_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  layer_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .req_mask(req_mask), .err_clr(err_clr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model, two-cycle read latency.
  logic [15:0] mem [256];
  logic [15:0] p0 = '0, p1 = '0;
  initial for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        p0 <= mem[ram_addr[7:0]];
    end
    p1 <= p0;
  end
  assign ram_rdata = p1;

  logic [15:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 | 16'(i);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; logic [15:0] data; int due; } rd_exp_t;
  typedef struct { int id; int len; int gap; } gnt_exp_t;
  rd_exp_t  rq[$];
  gnt_exp_t gq[$];

  task automatic exp_gnt(input int id, input int len, input int gap);
    gnt_exp_t g;
    g.id = id; g.len = len; g.gap = gap;
    gq.push_back(g);
  endtask

  // Requester driver state.
  int          rem[4], rep[4];
  logic [15:0] nxt_addr[4];
  logic        wr_m[4], nolast[4];

  initial for (int k = 0; k < 4; k++) begin
    rem[k] = 0; rep[k] = 0; nxt_addr[k] = '0; wr_m[k] = 1'b0; nolast[k] = 1'b0;
  end

  task automatic start(input int k, input int n, input logic [15:0] a, input logic wr, input logic nl);
    rem[k] = n; nxt_addr[k] = a; wr_m[k] = wr; nolast[k] = nl;
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      bus.req[k]  = (rem[k] > 0);
      bus.we[k]   = wr_m[k];
      bus.last[k] = (rem[k] == 1) && !nolast[k];
      bus.addr[k*AW +: AW]  = nxt_addr[k];
      bus.wdata[k*DW +: DW] = 16'h5000 + nxt_addr[k];
    end
  endtask

  logic [3:0] gnt_s = '0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (gnt_s[k] && bus.req[k]) begin
        rem[k]--;
        nxt_addr[k]++;
        if (rem[k] == 0 && rep[k] > 0) begin
          rep[k]--;
          rem[k] = 1;
        end
      end
    end
    drive();
  endtask

  function automatic bit pending();
    for (int k = 0; k < 4; k++) if (rem[k] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while (pending() || bus.gnt != 0) begin
      step();
      n++;
      if (n > 200) begin
        n_tests++; n_fail++;
        $display("FAIL wait_done: timeout, gnt %0h", bus.gnt);
        break;
      end
    end
    repeat (LAT + 2) step();
  endtask

  // Monitor: read-return scoreboard, grant order/length/gap, idle port check.
  logic [3:0] prev_gnt = '0;
  int zero_cnt = 0, len_cnt = 0, cur_len = -1;
  always @(negedge clk) begin
    if (rst) begin
      gnt_s = '0; prev_gnt = '0; zero_cnt = 0; cur_len = -1;
    end else begin
      gnt_s = bus.gnt;
      if (bus.rd_valid != 0) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: rd_valid %0h, none expected", bus.rd_valid);
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          chk("rd_id", 32'(bus.rd_valid), 32'(1) << r.id);
          chk("rd_data", 32'(bus.rd_data), 32'(r.data));
          chk("rd_lat", cyc, r.due);
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        n_tests++; n_fail++;
        $display("FAIL rd_missing: got rd_valid 0 expected id %0d", rq[0].id);
        void'(rq.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.req[k] && bus.gnt[k]) begin
          logic [7:0] a;
          a = bus.addr[k*AW +: 8];
          if (bus.we[k]) ref_mem[a] = bus.wdata[k*DW +: DW];
          else begin
            rd_exp_t r;
            r.id = k; r.data = ref_mem[a]; r.due = cyc + LAT;
            rq.push_back(r);
          end
        end
      end
      if (bus.gnt != 0 && prev_gnt == 0) begin
        if (gq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL gnt_unexpected: gnt %0h, none expected", bus.gnt);
          cur_len = -1;
        end else begin
          gnt_exp_t g;
          g = gq.pop_front();
          chk("gnt_id", 32'(bus.gnt), 32'(1) << g.id);
          if (g.gap >= 0) chk("gnt_gap", zero_cnt, g.gap);
          cur_len = g.len;
        end
        len_cnt = 1;
      end else if (bus.gnt != 0) begin
        len_cnt++;
      end else if (prev_gnt != 0) begin
        if (cur_len >= 0) chk("gnt_len", len_cnt, cur_len);
        zero_cnt = 1;
      end else begin
        zero_cnt++;
      end
      if (bus.gnt == 0) chk("idle_ram_en", {30'd0, ram_en, ram_we}, 32'd0);
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    bus.req = '0; bus.we = '0; bus.last = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(burst_err), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    rst = 1'b0;
    step();

    // Contention 1,2,3 with 2-beat reads, one bubble between grants.
    exp_gnt(1, 2, -1); exp_gnt(2, 2, 1); exp_gnt(3, 2, 1);
    start(1, 2, 16'h0020, 1'b0, 1'b0);
    start(2, 2, 16'h0030, 1'b0, 1'b0);
    start(3, 2, 16'h0050, 1'b0, 1'b0);
    drive();
    wait_done();

    // Pointer wrapped to 0: writer 0 then reader 1 of the written words.
    exp_gnt(0, 2, -1); exp_gnt(1, 2, 1);
    start(0, 2, 16'h0040, 1'b1, 1'b0);
    start(1, 2, 16'h0040, 1'b0, 1'b0);
    drive();
    wait_done();
    chk("wr_mem40", 32'(mem[8'h40]), 32'h5040);

    // Single 4-beat read by requester 1, grant one cycle after req.
    exp_gnt(1, 4, -1);
    start(1, 4, 16'h0010, 1'b0, 1'b0);
    drive();
    chk("req_gnt_lat0", 32'(bus.gnt), 0);
    step();
    chk("req_gnt_lat1", 32'(bus.gnt), 32'b0010);
    chk("busy_on", 32'(busy), 1);
    wait_done();
    chk("busy_off", 32'(busy), 0);

    // Mask blocks requester 2 until enabled; clearing mid-burst keeps burst.
    req_mask = 4'b1011;
    exp_gnt(2, 4, -1);
    start(2, 4, 16'h0060, 1'b0, 1'b0);
    drive();
    repeat (3) begin
      step();
      chk("mask_block", 32'(bus.gnt), 0);
    end
    req_mask = 4'b1111;
    step();
    chk("mask_open", 32'(bus.gnt), 32'b0100);
    req_mask = 4'b1011;
    step(); step();
    chk("mask_hold", 32'(bus.gnt), 32'b0100);
    wait_done();
    req_mask = 4'b1111;

    // Forced release after 4 beats, regrant for remaining 2, then withdraw.
    chk("err_pre", 32'(burst_err), 0);
    exp_gnt(3, 4, -1); exp_gnt(3, 3, 1);
    start(3, 6, 16'h0070, 1'b0, 1'b1);
    drive();
    wait_done();
    chk("err_set", 32'(burst_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'(burst_err), 0);

    // Handover: requester 1's last reads return during requester 2's grant.
    exp_gnt(1, 2, -1); exp_gnt(2, 2, 1);
    start(1, 2, 16'h0010, 1'b0, 1'b0);
    start(2, 2, 16'h0020, 1'b0, 1'b0);
    drive();
    wait_done();

    // Reset mid-burst: grant and in-flight read strobes vanish immediately.
    exp_gnt(1, -1, -1);
    start(1, 8, 16'h0090, 1'b0, 1'b0);
    drive();
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(bus.gnt), 0);
    chk("rst_mid_rdv", 32'(bus.rd_valid), 0);
    chk("rst_mid_ram_en", 32'(ram_en), 0);
    rq.delete();
    for (int k = 0; k < 4; k++) begin rem[k] = 0; rep[k] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // All four request 1-beat reads; requester 0 re-requests twice more.
`ifdef LAYER_RAM_ARB_PCIE_PRIO_EN
    exp_gnt(0, 1, -1); exp_gnt(0, 1, 1); exp_gnt(0, 1, 1);
    exp_gnt(1, 1, 1);  exp_gnt(2, 1, 1); exp_gnt(3, 1, 1);
`else
    exp_gnt(0, 1, -1); exp_gnt(1, 1, 1); exp_gnt(2, 1, 1);
    exp_gnt(3, 1, 1);  exp_gnt(0, 1, 1); exp_gnt(0, 1, 1);
`endif
    start(0, 1, 16'h0080, 1'b0, 1'b0);
    start(1, 1, 16'h00A0, 1'b0, 1'b0);
    start(2, 1, 16'h00B0, 1'b0, 1'b0);
    start(3, 1, 16'h00C0, 1'b0, 1'b0);
    rep[0] = 2;
    drive();
    wait_done();

    chk("gnt_queue_empty", gq.size(), 0);
    chk("rd_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
